// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: fetch / execute / load writeback / interrupt.
// Build option: define CU_FSM_INTR_EN to enable the interrupt path.
module otter_cu_fsm #(
    parameter int INIT_CYCLES = 1,
    parameter int RET_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             intr,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             mem_rdy,
    output logic             pcWrite,
    output logic             regWrite,
    output logic             memWE2,
    output logic             memRDEN1,
    output logic             memRDEN2,
    output logic             reset,
    output logic             csr_WE,
    output logic             int_taken,
    output logic [RET_W-1:0] instret
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

`ifdef CU_FSM_INTR_EN
    localparam logic INTR_EN = 1'b1;
`else
    localparam logic INTR_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] init_cnt;
    logic             intr_req;
    logic             retire;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_alu;
    logic             is_sys;

    assign intr_req  = intr & INTR_EN;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_sys    = (opcode == OP_SYS);
    assign is_alu    = (opcode == OP_LUI)   || (opcode == OP_AUIPC) ||
                       (opcode == OP_JAL)   || (opcode == OP_JALR)  ||
                       (opcode == OP_IMM)   || (opcode == OP_RG3);

    // Retirement is any PC update outside the interrupt vector load.
    assign retire = pcWrite &&
                    (state == ST_EXEC || state == ST_WB);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            instret  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + 1'b1;
            if (retire)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (is_load)
                    state_nxt = ST_WB;
                else
                    state_nxt = intr_req ? ST_INTR : ST_FETCH;
            end
            ST_WB: begin
                if (mem_rdy)
                    state_nxt = intr_req ? ST_INTR : ST_FETCH;
            end
            ST_INTR: state_nxt = ST_FETCH;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        // A live reset overrides the state so an in-flight store never writes.
        if (RST) begin
            reset = 1'b1;
        end else begin
            unique case (state)
                ST_INIT:  reset    = 1'b1;
                ST_FETCH: memRDEN1 = 1'b1;
                ST_EXEC: begin
                    unique case (1'b1)
                        is_load: memRDEN2 = 1'b1;
                        is_store: begin
                            memWE2  = 1'b1;
                            pcWrite = 1'b1;
                        end
                        is_alu: begin
                            pcWrite  = 1'b1;
                            regWrite = 1'b1;
                        end
                        is_sys: begin
                            pcWrite = 1'b1;
                            if (func3 != 3'b000) begin
                                regWrite = 1'b1;
                                csr_WE   = 1'b1;
                            end
                        end
                        is_branch: pcWrite = 1'b1;
                        default:   pcWrite = 1'b1;
                    endcase
                end
                ST_WB: begin
                    if (mem_rdy) begin
                        regWrite = 1'b1;
                        pcWrite  = 1'b1;
                    end
                end
                ST_INTR: begin
                    pcWrite   = 1'b1;
                    int_taken = INTR_EN;
                end
                default: reset = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Randomized instruction-level bench for otter_cu_fsm.
// Expected outputs come from per-instruction rules, not the FSM encoding.
module tb_otter_cu_fsm;

    localparam int RET_W = 4;

    localparam logic [7:0] V_NONE  = 8'h00;
    localparam logic [7:0] V_RST   = 8'h04;
    localparam logic [7:0] V_FETCH = 8'h10;
    localparam logic [7:0] V_WB    = 8'hC0;
`ifdef CU_FSM_INTR_EN
    localparam logic [7:0] V_INTR  = 8'h81;
`endif

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] ADDI   = 7'b0010011;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             intr = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       func3 = '0;
    logic             mem_rdy = 1'b0;
    logic             pcWrite;
    logic             regWrite;
    logic             memWE2;
    logic             memRDEN1;
    logic             memRDEN2;
    logic             reset;
    logic             csr_WE;
    logic             int_taken;
    logic [RET_W-1:0] instret;
    logic [7:0]       outs;

    int errors = 0;
    int checks = 0;
    int model_ret = 0;

    otter_cu_fsm #(
        .INIT_CYCLES(1),
        .RET_W(RET_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .intr(intr),
        .opcode(opcode),
        .func3(func3),
        .mem_rdy(mem_rdy),
        .pcWrite(pcWrite),
        .regWrite(regWrite),
        .memWE2(memWE2),
        .memRDEN1(memRDEN1),
        .memRDEN2(memRDEN2),
        .reset(reset),
        .csr_WE(csr_WE),
        .int_taken(int_taken),
        .instret(instret)
    );

    always #5 CLK = ~CLK;

    assign outs = {pcWrite, regWrite, memWE2, memRDEN1,
                   memRDEN2, reset, csr_WE, int_taken};

    // Execute-cycle enables an instruction class must produce.
    function automatic logic [7:0] exp_exec(logic [6:0] op, logic [2:0] f3);
        logic [6:0] alu_ops [6];
        alu_ops = '{7'b0110111, 7'b0010111, 7'b1101111,
                    7'b1100111, 7'b0010011, 7'b0110011};
        if (op == LOAD)  return 8'h08;
        if (op == STORE) return 8'hA0;
        foreach (alu_ops[i])
            if (op == alu_ops[i]) return 8'hC0;
        if (op == SYSTEM) return (f3 != 3'b000) ? 8'hC2 : 8'h80;
        return 8'h80;
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int stall, input logic irq);
        logic [7:0] e;
        opcode  = 7'($urandom);
        func3   = 3'($urandom);
        intr    = 1'($urandom);
        mem_rdy = 1'($urandom);
        @(negedge CLK);
        checks++;
        if (outs !== V_FETCH) begin
            errors++;
            $display("FAIL fetch outs=%h want=%h", outs, V_FETCH);
        end
        checks++;
        if (instret !== RET_W'(model_ret)) begin
            errors++;
            $display("FAIL fetch_instret got=%0d want=%0d",
                     instret, RET_W'(model_ret));
        end
        next_cycle();
        opcode  = op;
        func3   = f3;
        intr    = (op == LOAD) ? 1'($urandom) : irq;
        mem_rdy = 1'($urandom);
        e = exp_exec(op, f3);
        @(negedge CLK);
        checks++;
        if (outs !== e) begin
            errors++;
            $display("FAIL exec op=%b f3=%b outs=%h want=%h", op, f3, outs, e);
        end
        next_cycle();
        if (op == LOAD) begin
            for (int k = 0; k < stall; k++) begin
                mem_rdy = 1'b0;
                intr    = 1'($urandom);
                @(negedge CLK);
                checks++;
                if (outs !== V_NONE) begin
                    errors++;
                    $display("FAIL wb_stall k=%0d outs=%h want=%h", k, outs, V_NONE);
                end
                next_cycle();
            end
            mem_rdy = 1'b1;
            intr    = irq;
            @(negedge CLK);
            checks++;
            if (outs !== V_WB) begin
                errors++;
                $display("FAIL wb outs=%h want=%h", outs, V_WB);
            end
            next_cycle();
        end
        model_ret++;
`ifdef CU_FSM_INTR_EN
        if (irq) begin
            intr = 1'($urandom);
            @(negedge CLK);
            checks++;
            if (outs !== V_INTR) begin
                errors++;
                $display("FAIL intr outs=%h want=%h", outs, V_INTR);
            end
            checks++;
            if (instret !== RET_W'(model_ret)) begin
                errors++;
                $display("FAIL intr_instret got=%0d want=%0d",
                         instret, RET_W'(model_ret));
            end
            next_cycle();
        end
`endif
        intr = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) next_cycle();
        RST = 1'b0;
        next_cycle();
        model_ret = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (outs !== V_RST || instret !== '0) begin
                errors++;
                $display("FAIL reset_hold outs=%h instret=%0d want=%h/0",
                         outs, instret, V_RST);
            end
            next_cycle();
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (outs !== V_RST) begin
            errors++;
            $display("FAIL init outs=%h want=%h", outs, V_RST);
        end
        next_cycle();
        model_ret = 0;
    endtask

    task automatic test_addi();
        run_instr(ADDI, 3'b000, 0, 1'b0);
        run_instr(ADDI, 3'b111, 0, 1'b0);
    endtask

    task automatic test_load_stall();
        run_instr(LOAD, 3'b010, 3, 1'b0);
        run_instr(LOAD, 3'b000, 0, 1'b0);
    endtask

    task automatic test_csr();
        run_instr(SYSTEM, 3'b001, 0, 1'b0);
        run_instr(SYSTEM, 3'b000, 0, 1'b0);
    endtask

    task automatic test_store_reset();
        run_instr(ADDI, 3'b000, 0, 1'b0);
        @(negedge CLK);
        next_cycle();
        opcode = STORE;
        func3  = 3'b010;
        RST    = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs !== V_RST) begin
            errors++;
            $display("FAIL store_rst outs=%h want=%h", outs, V_RST);
        end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (outs !== V_RST || instret !== '0) begin
            errors++;
            $display("FAIL store_rst_init outs=%h instret=%0d want=%h/0",
                     outs, instret, V_RST);
        end
        next_cycle();
        model_ret = 0;
    endtask

    task automatic test_intr();
        run_instr(ADDI, 3'b000, 0, 1'b1);
        run_instr(STORE, 3'b010, 0, 1'b1);
        run_instr(LOAD, 3'b010, 2, 1'b1);
        run_instr(ADDI, 3'b000, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++)
            run_instr(ADDI, 3'b000, 0, 1'b0);
        checks++;
        if (instret !== 4'hF) begin
            errors++;
            $display("FAIL wrap_max got=%0d want=15", instret);
        end
        run_instr(ADDI, 3'b000, 0, 1'b0);
        checks++;
        if (instret !== 4'h0) begin
            errors++;
            $display("FAIL wrap_zero got=%0d want=0", instret);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [6:0] op;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                7'b0110011, 7'b1110011, 7'b0001111, 7'b0000000};
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0)
                op = 7'($urandom);
            run_instr(op, 3'($urandom), $urandom_range(0, 3),
                      1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_stall();
        test_csr();
        test_store_reset();
        test_intr();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
